// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// op encodings, FSM state type and operand magnitude helper.
package ex_muldiv_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-facing bundle of the multiply/divide unit: op request, squash,
// stall back-pressure and HI/LO results.
interface ex_muldiv_unit_if
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  stall, busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output stall, busy, done, hi, lo, div_by_zero
    );

endinterface

// File: rtl/ex_muldiv_unit_step.sv
// One iteration of the 64-bit accumulator: shift-add for multiply,
// restoring shift-subtract for divide (remainder high, quotient low).
module ex_muldiv_step
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, opnd};
        rem_sh  = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        diff    = rem_sh - {1'b0, opnd};
        acc_out = '0;
        if (is_div) begin
            // remainder stays below the divisor, so a borrow shows up in the top bit
            if (!diff[XLEN])
                acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            else
                acc_out = {rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        end else if (acc_in[0]) begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end else begin
            acc_out = {1'b0, acc_in[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit in EX: magnitudes are iterated for
// XLEN cycles, signs are applied in FIX, and stall holds ID/EX until done.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    ex_muldiv_unit_if.slave   bus
);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] fixed;
    logic [XLEN-1:0]   opnd;
    logic              is_div;
    logic              neg_res;
    logic              neg_rem;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              done_q;
    logic              busy_q;
    logic              dbz_q;

    logic              accept;
    logic              dbz_hit;
    logic              op_signed;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    assign op_signed = ~bus.op[0];
    assign accept    = (state == S_IDLE) && bus.start && !bus.flush;
    assign dbz_hit   = accept && bus.op[1] && (bus.operand_b == '0);
    assign mag_a     = magnitude(bus.operand_a, op_signed);
    assign mag_b     = magnitude(bus.operand_b, op_signed);

    assign bus.stall       = bus.start && (state != S_DONE);
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

    ex_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .opnd    (opnd),
        .acc_out (acc_step)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = dbz_hit ? S_DONE : S_CALC;
            S_CALC:  if (cnt == '0) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.flush)
            state_next = S_IDLE;
    end

    always_comb begin
        fixed = acc;
        if (is_div) begin
            fixed[2*XLEN-1:XLEN] = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
            fixed[XLEN-1:0]      = neg_res ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
        end else if (neg_res) begin
            fixed = -acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state_next == S_DONE);
            busy_q <= (state_next == S_CALC) || (state_next == S_FIX);
            if (accept) begin
                is_div  <= bus.op[1];
                neg_res <= op_signed && (bus.operand_a[XLEN-1] ^ bus.operand_b[XLEN-1]);
                neg_rem <= op_signed && bus.operand_a[XLEN-1];
                cnt     <= CNT_W'(XLEN - 1);
                dbz_q   <= dbz_hit;
                // multiplier/dividend seeds the low half; the other magnitude feeds the step
                acc     <= {{XLEN{1'b0}}, bus.op[1] ? mag_a : mag_b};
                opnd    <= bus.op[1] ? mag_b : mag_a;
                if (dbz_hit) begin
                    hi_q <= bus.operand_a;
                    lo_q <= '1;
                end
            end else if (state == S_CALC && !bus.flush) begin
                acc <= acc_step;
                cnt <= cnt - CNT_W'(1);
            end else if (state == S_FIX && !bus.flush) begin
                hi_q <= fixed[2*XLEN-1:XLEN];
                lo_q <= fixed[XLEN-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: latency, stall shape, results,
// divide-by-zero, flush and asynchronous reset.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;

    ex_muldiv_unit_if #(.XLEN(32)) bus();

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_now  = 0;
    int done_at  = 0;

    always @(posedge clk) cyc_now++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues an op at the next cycle boundary; start drops after 'hold' cycles.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input int hold,
                         input logic [31:0] eh, input logic [31:0] el);
        bit stall_ok = 1'b1;
        bit seen     = 1'b0;
        int cyc      = 0;
        @(posedge clk);
        #1;
        bus.op        = o;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        while (cyc <= 60) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.stall !== bus.start) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc >= hold) bus.start = 1'b0;
        end
        check({tag, " done"},    64'(seen),      64'd1);
        check({tag, " latency"}, 64'(cyc),       64'(lat));
        check({tag, " stall"},   64'(stall_ok),  64'd1);
        check({tag, " release"}, 64'(bus.stall), 64'd0);
        check({tag, " hilo"},    {bus.hi, bus.lo}, {eh, el});
        done_at = cyc_now;
    endtask

    task automatic idle_cycles(input int n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t_first;
        bit  saw_done;
        bus.start     = 1'b0;
        bus.op        = OP_MULT;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.flush     = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset hilo",  {bus.hi, bus.lo},     64'd0);
        check("reset done",  64'(bus.done),        64'd0);
        check("reset busy",  64'(bus.busy),        64'd0);
        check("reset dbz",   64'(bus.div_by_zero), 64'd0);
        check("reset stall", 64'(bus.stall),       64'd0);

        do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1000, 32'hFFFFFFFE, 32'h00000001);
        idle_cycles(0);
        check("done pulse", 64'(bus.done), 64'd0);
        check("busy idle",  64'(bus.busy), 64'd0);

        do_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 34, 1000, 32'hFFFFFFFF, 32'hFFFFFFEB);
        t_first = done_at;
        do_op("divu_b2b", OP_DIVU, 32'd100, 32'd7, 34, 1000, 32'd2, 32'd14);
        check("b2b gap", 64'(done_at - t_first), 64'd35);

        do_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 34, 1000, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 3, 32'h0, 32'h80000000);
        idle_cycles(5);
        check("idle hold hilo", {bus.hi, bus.lo}, {32'h0, 32'h80000000});

        do_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 1, 1000, 32'd5, 32'hFFFFFFFF);
        check("dbz set", 64'(bus.div_by_zero), 64'd1);
        idle_cycles(3);
        check("dbz sticky", 64'(bus.div_by_zero), 64'd1);

        do_op("divu_clr", OP_DIVU, 32'd100, 32'd7, 34, 1000, 32'd2, 32'd14);
        check("dbz cleared", 64'(bus.div_by_zero), 64'd0);
        idle_cycles(1);

        @(posedge clk);
        #1;
        bus.op        = OP_MULT;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd9;
        bus.start     = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush busy before", 64'(bus.busy),  64'd1);
        check("flush stall",       64'(bus.stall), 64'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush busy after",  64'(bus.busy),  64'd0);
        check("flush stall after", 64'(bus.stall), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        check("flush no done", 64'(saw_done),      64'd0);
        check("flush hilo",    {bus.hi, bus.lo},   {32'd2, 32'd14});
        check("flush dbz",     64'(bus.div_by_zero), 64'd0);

        @(posedge clk);
        #1;
        bus.op        = OP_MULTU;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd9;
        bus.start     = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre-rst busy", 64'(bus.busy), 64'd1);
        #1 bus.start = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async rst hilo", {bus.hi, bus.lo}, 64'd0);
        check("async rst busy", 64'(bus.busy),    64'd0);
        check("async rst done", 64'(bus.done),    64'd0);
        #1 rst = 1'b0;

        do_op("multu_rst", OP_MULTU, 32'd6, 32'd7, 34, 1000, 32'd0, 32'd42);
        idle_cycles(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
